// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of a 5-stage pipeline.
//
// Holds the PC, presents it to instruction memory, and registers the fetched
// word together with its PC+4 into the IF/ID pipeline register. A branch
// resolved taken in ID redirects the PC and flushes IF/ID, which inserts one
// bubble. Free-running counters record stalled cycles and IF/ID flushes.
//
// Ports
//   clk         in   1  clock, rising edge
//   reset       in   1  asynchronous, active-high
//   PCWrite     in   1  1 = PC may update, 0 = PC holds
//   IFID_write  in   1  1 = IF/ID may load, 0 = IF/ID holds
//   br_taken    in   1  ID-stage branch resolved taken
//   br_target   in  32  ID-stage branch target
//   imem_addr   out 32  instruction memory address (= PC)
//   imem_rdata  in  32  instruction word at imem_addr (combinational)
//   IFID_instr  out 32  registered instruction
//   IFID_pc4    out 32  registered PC+4 of IFID_instr
//   IFID_valid  out  1  1 = real instruction, 0 = bubble
//   stall_cnt   out 16  cycles with PCWrite=0 (saturating)
//   flush_cnt   out 16  IF/ID flushes (saturating)
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFID_write,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_pc4,
  output logic        IFID_valid,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // Word alignment of the reset vector is enforced here so PC[1:0] is
  // always zero regardless of how the parameter is set.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic [31:0] w_pc4;
  logic        w_redirect;
  logic        w_flush;

  assign w_pc4      = r_pc + 32'd4;
  // A branch seen while the PC is stalled is not yet resolved; ignore it.
  assign w_redirect = br_taken & PCWrite;
  assign w_flush    = w_redirect & IFID_write;

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC_ALIGNED;
    end else if (PCWrite) begin
      if (w_redirect) begin
        r_pc <= {br_target[31:2], 2'b00};
      end else begin
        r_pc <= w_pc4;
      end
    end
  end

  // IF/ID pipeline register; flush has priority over a normal load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else if (w_flush) begin
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else if (IFID_write) begin
      r_ifid_instr <= imem_rdata;
      r_ifid_pc4   <= w_pc4;
      r_ifid_valid <= 1'b1;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (!PCWrite && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign imem_addr  = r_pc;
  assign IFID_instr = r_ifid_instr;
  assign IFID_pc4   = r_ifid_pc4;
  assign IFID_valid = r_ifid_valid;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// A behavioural model tracks the architectural fetch state (PC, IF/ID
// contents, counters) and every edge the DUT is compared against it.
// A second instance with RESET_PC = FFFF_FFF8 free-runs to show PC wrap.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] IMEM_XOR = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        IFID_write;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pc4;
  logic        IFID_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // wrap-test instance: always fetching, never branching
  logic        wr_one  = 1'b1;
  logic        wr_zero = 1'b0;
  logic [31:0] wr_tgt  = 32'd0;
  logic [31:0] wr_addr;
  logic [31:0] wr_rdata;
  logic [31:0] wr_instr;
  logic [31:0] wr_pc4;
  logic        wr_valid;
  logic [15:0] wr_stall;
  logic [15:0] wr_flush;

  always #5 clk = ~clk;

  // instruction memory: word content is a fixed function of the address
  assign imem_rdata = imem_addr ^ IMEM_XOR;
  assign wr_rdata   = wr_addr ^ IMEM_XOR;

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .PCWrite    (PCWrite),
    .IFID_write (IFID_write),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .IFID_instr (IFID_instr),
    .IFID_pc4   (IFID_pc4),
    .IFID_valid (IFID_valid),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk        (clk),
    .reset      (reset),
    .PCWrite    (wr_one),
    .IFID_write (wr_one),
    .br_taken   (wr_zero),
    .br_target  (wr_tgt),
    .imem_addr  (wr_addr),
    .imem_rdata (wr_rdata),
    .IFID_instr (wr_instr),
    .IFID_pc4   (wr_pc4),
    .IFID_valid (wr_valid),
    .stall_cnt  (wr_stall),
    .flush_cnt  (wr_flush)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          m_stall;
  int          m_flush;

  task automatic model_reset();
    m_pc    = 32'd0;
    m_instr = 32'd0;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // one rising edge worth of architectural behaviour
  task automatic model_edge();
    logic        taken_now;
    logic [31:0] next_seq;
    if (reset) return;
    taken_now = br_taken && PCWrite;
    next_seq  = m_pc + 32'd4;
    if (taken_now && IFID_write) begin
      m_instr = 32'd0;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
      if (m_flush < 65535) m_flush++;
    end else if (IFID_write) begin
      m_instr = m_pc ^ IMEM_XOR;
      m_pc4   = next_seq;
      m_valid = 1'b1;
    end
    if (!PCWrite) begin
      if (m_stall < 65535) m_stall++;
    end else if (taken_now) begin
      m_pc = br_target & 32'hFFFF_FFFC;
    end else begin
      m_pc = next_seq;
    end
  endtask

  task automatic compare_all();
    check_val("pc",    imem_addr, m_pc);
    check_val("instr", IFID_instr, m_instr);
    check_val("pc4",   IFID_pc4, m_pc4);
    check_val("valid", {31'd0, IFID_valid}, {31'd0, m_valid});
    check_val("stall", {16'd0, stall_cnt}, m_stall[31:0]);
    check_val("flush", {16'd0, flush_cnt}, m_flush[31:0]);
  endtask

  task automatic step(input bit chk);
    @(posedge clk);
    model_edge();
    #1;
    if (chk) compare_all();
  endtask

  task automatic set_in(input logic pw, input logic iw, input logic bt, input logic [31:0] tg);
    PCWrite    = pw;
    IFID_write = iw;
    br_taken   = bt;
    br_target  = tg;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    $display("reset held");
    compare_all();
    reset = 1'b0;

    // sequential fetch
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      $display("seq fetch pc=%h instr=%h", imem_addr, IFID_instr);
    end
    check_val("seq_pc10", imem_addr, 32'h10);
    check_val("seq_instr", IFID_instr, 32'hC ^ IMEM_XOR);

    // stall with an unresolved branch present
    set_in(1'b0, 1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) step(1'b1);
    $display("stall pc=%h stall_cnt=%0d", imem_addr, stall_cnt);
    check_val("stall_pc", imem_addr, 32'h10);
    check_val("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
    check_val("stall_flush0", {16'd0, flush_cnt}, 32'd0);

    // advance to 0x20 then take a branch to an unaligned target
    set_in(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1);
    set_in(1'b1, 1'b1, 1'b1, 32'h103);
    step(1'b1);
    $display("branch pc=%h valid=%0d flush=%0d", imem_addr, IFID_valid, flush_cnt);
    check_val("br_pc", imem_addr, 32'h100);
    check_val("br_bubble", {31'd0, IFID_valid}, 32'd0);
    check_val("br_flush1", {16'd0, flush_cnt}, 32'd1);
    set_in(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1);
    check_val("br_instr", IFID_instr, 32'h100 ^ IMEM_XOR);
    check_val("br_pc4", IFID_pc4, 32'h104);

    // independent enables
    set_in(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1);
    set_in(1'b0, 1'b1, 1'b1, 32'h40);
    step(1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
             $urandom_range(0, 3) == 0, $urandom);
      step(1'b1);
    end

    // async reset in the middle of a redirect cycle
    set_in(1'b1, 1'b1, 1'b1, 32'h0000_0800);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    $display("async reset mid-redirect");
    compare_all();
    step(1'b1);
    reset = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'd0);
    check_val("wrap_pc0", wr_addr, 32'hFFFF_FFF8);
    step(1'b1);
    check_val("rel_pc", imem_addr, 32'h4);
    check_val("wrap_pc1", wr_addr, 32'hFFFF_FFFC);
    check_val("wrap_pc4a", wr_pc4, 32'hFFFF_FFFC);
    step(1'b1);
    check_val("wrap_pc2", wr_addr, 32'h0);
    check_val("wrap_pc4b", wr_pc4, 32'h0);
    check_val("wrap_instr", wr_instr, 32'hFFFF_FFFC ^ IMEM_XOR);

    // stall counter saturation
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 65540; i++) step(1'b0);
    $display("saturation stall_cnt=%h", stall_cnt);
    compare_all();
    check_val("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    step(1'b1);
    check_val("stall_sat2", {16'd0, stall_cnt}, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: PCWrite  input  1  from branch hazard unit; 1 = PC may update, 0 = PC holds.
REQ-004 SHALL have port: IFID_write  input  1  from branch hazard unit; 1 = IF/ID register may load, 0 = holds.
REQ-005 SHALL have port: br_taken  input  1  ID-stage branch resolved taken this cycle.
REQ-006 SHALL have port: br_target  input  32  ID-stage branch target address.
REQ-007 SHALL have port: imem_addr  output  32  instruction memory address; equals PC.
REQ-008 SHALL have port: imem_rdata  input  32  instruction word at imem_addr, combinational, same cycle.
REQ-009 SHALL have port: IFID_instr  output  32  registered instruction to ID.
REQ-010 SHALL have port: IFID_pc4  output  32  registered PC+4 of IFID_instr.
REQ-011 SHALL have port: IFID_valid  output  1  1 = IFID_instr is a real fetched instruction, 0 = bubble.
REQ-012 SHALL have port: stall_cnt  output  16  count of cycles with PCWrite=0.
REQ-013 SHALL have port: flush_cnt  output  16  count of IF/ID flushes.
REQ-014 SHALL have parameter: RESET_PC, default 32'h0000_0000, PC value after reset.

Function
REQ-015 SHALL hold PC in a 32-bit register with bits [1:0] always 0; imem_addr SHALL equal PC combinationally.
REQ-016 SHALL compute pc4 = PC + 4 modulo 2^32; PC 32'hFFFF_FFFC SHALL produce pc4 32'h0000_0000.
REQ-017 SHALL define redirect = br_taken AND PCWrite; br_taken SHALL be ignored entirely while PCWrite=0 (stalled branch is unresolved).
REQ-018 SHALL update PC at each rising edge: PCWrite=0 -> hold; redirect -> {br_target[31:2],2'b00}; otherwise -> pc4.
REQ-019 SHALL update IF/ID at each rising edge, priority order: (a) redirect AND IFID_write -> flush: IFID_instr<=0, IFID_pc4<=0, IFID_valid<=0; (b) IFID_write=1 -> IFID_instr<=imem_rdata, IFID_pc4<=pc4, IFID_valid<=1; (c) IFID_write=0 -> hold all three.
REQ-020 SHALL treat PCWrite and IFID_write independently; PCWrite=1 with IFID_write=0 advances PC while IF/ID holds (the skipped fetch is lost); PCWrite=0 with IFID_write=1 reloads IF/ID from the unchanged PC.
REQ-021 SHALL latency: instruction at PC appears on IFID_instr exactly one rising edge after PC presents it with IFID_write=1; redirect costs exactly one bubble (IFID_valid=0 for one cycle).
REQ-022 SHALL increment stall_cnt by 1 on each rising edge where PCWrite=0, saturating at 16'hFFFF.
REQ-023 SHALL increment flush_cnt by 1 on each rising edge where REQ-019(a) occurs, saturating at 16'hFFFF.
REQ-024 SHALL NOT generate combinational paths from br_taken/br_target/PCWrite/IFID_write to any IFID_* output or counter.

Reset
REQ-025 SHALL, while reset=1, force asynchronously: PC=RESET_PC, IFID_instr=0, IFID_pc4=0, IFID_valid=0, stall_cnt=0, flush_cnt=0.
REQ-026 SHALL, on reset assertion mid-stall or mid-redirect, discard the pending update; the first rising edge with reset=0 fetches from RESET_PC.
REQ-027 SHALL ignore all inputs on rising edges while reset=1.

Verification
REQ-028 Sequential fetch: reset release, PCWrite=IFID_write=1, br_taken=0, imem returns addr^32'hA5A5_0000 -> PC 0,4,8,...; IFID_instr lags PC one cycle; IFID_pc4 = its PC+4; IFID_valid=1 from second edge.
REQ-029 Stall: PC=0x10, PCWrite=IFID_write=0 for 3 cycles with br_taken=1, br_target=0x200 -> PC stays 0x10, IF/ID unchanged, stall_cnt=3, flush_cnt=0.
REQ-030 Taken branch: PC=0x20, br_taken=1, br_target=0x103, PCWrite=IFID_write=1 -> next PC=0x100, IFID_valid=0, IFID_instr=0, flush_cnt=1; following edge IFID_instr=imem[0x100], IFID_pc4=0x104.
REQ-031 Wrap: RESET_PC=32'hFFFF_FFF8, free-run -> PC FFFF_FFF8, FFFF_FFFC, 0000_0000; IFID_pc4 for FFFF_FFFC = 0.
REQ-032 Saturation: hold PCWrite=0 for 65540 cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-033 Async reset: assert reset between edges during a redirect cycle -> all outputs reach reset values before next edge; after release PC=RESET_PC, counters 0.
